// File: rtl/ialu_pkg.sv
// Shared opcode constants for the integer ALU and its decoder, plus the
// shifter mode type used between the ALU and its shifter.
package ialu_pkg;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_SLL   = 5'd2;
    localparam logic [4:0] ALU_SLT   = 5'd3;
    localparam logic [4:0] ALU_SLTU  = 5'd4;
    localparam logic [4:0] ALU_XOR   = 5'd5;
    localparam logic [4:0] ALU_SRL   = 5'd6;
    localparam logic [4:0] ALU_SRA   = 5'd7;
    localparam logic [4:0] ALU_OR    = 5'd8;
    localparam logic [4:0] ALU_AND   = 5'd9;
    localparam logic [4:0] ALU_PASSB = 5'd10;
    localparam logic [4:0] ALU_ADD4  = 5'd11;
    localparam logic [4:0] ALU_EQ    = 5'd12;
    localparam logic [4:0] ALU_NE    = 5'd13;
    localparam logic [4:0] ALU_GE    = 5'd14;
    localparam logic [4:0] ALU_GEU   = 5'd15;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } shift_mode_e;

endpackage

// File: rtl/ialu_shifter.sv
// Barrel shifter for the integer ALU: logical left, logical right and
// arithmetic right by an amount taken from the low bits of operand B.
module ialu_shifter
    import ialu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   shamt,
    input  shift_mode_e      mode,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = a;
        case (mode)
            SH_SLL:  y = a << shamt;
            SH_SRL:  y = a >> shamt;
            SH_SRA:  y = $signed(a) >>> shamt;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/ialu.sv
// Integer ALU: combinational result from a, b, op plus a registered copy.
// Compares are derived from the flags of the shared subtractor.
module ialu
    import ialu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       op,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_q
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] sh_y;
    logic             carry;
    logic             zero;
    logic             ovf;
    logic             lt_s;
    logic             lt_u;
    shift_mode_e      sh_mode;

    function automatic logic [WIDTH-1:0] flag(input logic f);
        return {{(WIDTH-1){1'b0}}, f};
    endfunction

    // ADD4 shares the adder with ADD by swapping the B operand for a constant.
    assign add_b = (op == ALU_ADD4) ? WIDTH'(4) : b;
    assign sum   = a + add_b;

    // a - b as a + ~b + 1; carry out set means no borrow, i.e. a >= b unsigned.
    assign {carry, diff} = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign zero = (diff == '0);
    assign ovf  = (a[WIDTH-1] ^ b[WIDTH-1]) & (diff[WIDTH-1] ^ a[WIDTH-1]);
    assign lt_s = diff[WIDTH-1] ^ ovf;
    assign lt_u = ~carry;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        sh_mode = SH_SLL;
        case (op)
            ALU_SRL: sh_mode = SH_SRL;
            ALU_SRA: sh_mode = SH_SRA;
            default: sh_mode = SH_SLL;
        endcase
    end

    ialu_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .a     (a),
        .shamt (b[SHW-1:0]),
        .mode  (sh_mode),
        .y     (sh_y)
    );

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD, ALU_ADD4:         result = sum;
            ALU_SUB:                   result = diff;
            ALU_SLL, ALU_SRL, ALU_SRA: result = sh_y;
            ALU_SLT:                   result = flag(lt_s);
            ALU_SLTU:                  result = flag(lt_u);
            ALU_XOR:                   result = a ^ b;
            ALU_OR:                    result = a | b;
            ALU_AND:                   result = a & b;
            ALU_PASSB:                 result = b;
            ALU_EQ:                    result = flag(zero);
            ALU_NE:                    result = flag(~zero);
            ALU_GE:                    result = flag(~lt_s);
            ALU_GEU:                   result = flag(~lt_u);
            default:                   result = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) result_q <= '0;
        else        result_q <= result;
    end

endmodule

// File: tb/tb_ialu.sv
// Self-checking bench for ialu: directed vectors, reset/register behaviour,
// and a batch of random vectors checked against a behavioural model.
module tb_ialu;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic [31:0] result;
    logic [31:0] result_q;

    int checks   = 0;
    int failures = 0;

    ialu #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .op       (op),
        .result   (result),
        .result_q (result_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [31:0] va, input logic [31:0] vb, input logic [4:0] vop);
        a  = va;
        b  = vb;
        op = vop;
        #20;
    endtask

    function automatic logic [31:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic [4:0] mop);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        int unsigned        sh;
        sa = ma;
        sb = mb;
        sh = int'(mb % 32);
        case (mop)
            5'd0:  return ma + mb;
            5'd1:  return ma - mb;
            5'd2:  return ma << sh;
            5'd3:  return (sa < sb) ? 32'd1 : 32'd0;
            5'd4:  return (ma < mb) ? 32'd1 : 32'd0;
            5'd5:  return ma ^ mb;
            5'd6:  return ma >> sh;
            5'd7:  return sa >>> sh;
            5'd8:  return ma | mb;
            5'd9:  return ma & mb;
            5'd10: return mb;
            5'd11: return ma + 32'd4;
            5'd12: return (ma == mb) ? 32'd1 : 32'd0;
            5'd13: return (ma != mb) ? 32'd1 : 32'd0;
            5'd14: return (sa >= sb) ? 32'd1 : 32'd0;
            5'd15: return (ma >= mb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        a = '0; b = '0; op = '0;
        #12;
        check("reset_result_q", result_q, 32'h0);

        // wrap-around add/sub
        apply(32'hFFFF_FFFF, 32'h1, 5'd0);  check("add_wrap", result, 32'h0);
        apply(32'h0, 32'h1, 5'd1);          check("sub_wrap", result, 32'hFFFF_FFFF);

        // shifts, upper bits of b ignored
        apply(32'h8000_0000, 32'h21, 5'd7); check("sra_1", result, 32'hC000_0000);
        apply(32'h8000_0000, 32'h21, 5'd6); check("srl_1", result, 32'h4000_0000);
        apply(32'h8000_0000, 32'h21, 5'd2); check("sll_1", result, 32'h0);
        apply(32'h1234_5678, 32'h20, 5'd2); check("sll_0", result, 32'h1234_5678);
        apply(32'h8765_4321, 32'h40, 5'd7); check("sra_0", result, 32'h8765_4321);
        apply(32'h8000_0000, 32'h1F, 5'd7); check("sra_31", result, 32'hFFFF_FFFF);

        // compares, a=-5 b=3
        apply(32'hFFFF_FFFB, 32'd3, 5'd3);  check("slt_neg", result, 32'd1);
        apply(32'hFFFF_FFFB, 32'd3, 5'd4);  check("sltu_neg", result, 32'd0);
        apply(32'hFFFF_FFFB, 32'd3, 5'd14); check("ge_neg", result, 32'd0);
        apply(32'hFFFF_FFFB, 32'd3, 5'd15); check("geu_neg", result, 32'd1);
        apply(32'hFFFF_FFFB, 32'd3, 5'd12); check("eq_ne", result, 32'd0);
        apply(32'hFFFF_FFFB, 32'd3, 5'd13); check("ne_ne", result, 32'd1);
        apply(32'h8000_0000, 32'h7FFF_FFFF, 5'd3); check("slt_ovf", result, 32'd1);
        apply(32'h8000_0000, 32'h7FFF_FFFF, 5'd4); check("sltu_ovf", result, 32'd0);
        apply(32'h7FFF_FFFF, 32'h8000_0000, 5'd14); check("ge_ovf", result, 32'd1);
        apply(32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd12); check("eq_eq", result, 32'd1);
        apply(32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd14); check("ge_eq", result, 32'd1);
        apply(32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd3);  check("slt_eq", result, 32'd0);

        // logic and pass
        apply(32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd5);  check("xor", result, 32'hFF00_FF00);
        apply(32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd8);  check("or", result, 32'hFFF0_FFF0);
        apply(32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd9);  check("and", result, 32'h00F0_00F0);
        apply(32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd10); check("passb", result, 32'h0FF0_0FF0);
        apply(32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd11); check("add4", result, 32'hF0F0_F0F4);

        // reserved opcodes
        apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20); check("rsvd_20", result, 32'h0);
        apply(32'h1234_5678, 32'h9ABC_DEF0, 5'd31); check("rsvd_31", result, 32'h0);
        apply(32'h1, 32'h1, 5'd16);                 check("rsvd_16", result, 32'h0);

        // reset held: result_q stays 0 across edges
        check("reset_hold_q", result_q, 32'h0);

        // register and reset behaviour
        @(negedge clk);
        rst_n = 1'b1;
        a = 32'd2; b = 32'd3; op = 5'd0;
        @(posedge clk); #1;
        check("reg_add", result_q, 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear_q", result_q, 32'h0);
        check("reset_result_live", result, 32'd5);
        op = 5'd1;
        #1;
        check("reset_result_track", result, 32'hFFFF_FFFF);
        @(negedge clk);
        check("reset_q_stays", result_q, 32'h0);
        rst_n = 1'b1;
        op = 5'd9;
        #1;
        check("release_no_update", result_q, 32'h0);
        @(posedge clk); #1;
        check("first_edge_after_release", result_q, 32'd2);
        a = 32'h0000_00F0; b = 32'h0000_000F; op = 5'd8;
        @(posedge clk); #1;
        check("reg_or", result_q, 32'h0000_00FF);

        // random vectors against the behavioural model
        for (int i = 0; i < 16; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic [4:0]  rop;
            ra  = $urandom;
            rb  = $urandom;
            rop = 5'($urandom_range(0, 15));
            apply(ra, rb, rop);
            check($sformatf("rand_%0d_op%0d", i, rop), result, model(ra, rb, rop));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
